// File: rtl/pic_ctrl.sv
// pic_ctrl: 8-line fixed-priority interrupt controller with toggle-signalled
// interrupt output and a two-state in-service/EOI handshake.
//
// Parameters:
//   BASE_RST  - reset value of the vector base register
//   PORT_CMD  - EOI / vector-base write, IRR read; PORT_CMD+1 reads status
//   PORT_MASK - IMR write/read
// Ports:
//   clock, reset_n        - rising-edge clock, synchronous active-low reset
//   req[7:0]              - interrupt request strobes (0 = timer, 1 = kbd, 2 = vretrace)
//   port_a/port_w/port_r  - CPU I/O address and one-cycle write/read strobes
//   port_o / port_i       - CPU write data / registered read data
//   irq                   - toggles once per dispatched interrupt
//   irq_in                - vector number of the interrupt last signalled
//   busy                  - an interrupt is in service, EOI awaited
module pic_ctrl #(
    parameter logic [7:0]  BASE_RST  = 8'h08,
    parameter logic [15:0] PORT_CMD  = 16'h0020,
    parameter logic [15:0] PORT_MASK = 16'h00A0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  req,
    input  logic [15:0] port_a,
    input  logic        port_w,
    input  logic        port_r,
    input  logic [7:0]  port_o,
    output logic [7:0]  port_i,
    output logic        irq,
    output logic [7:0]  irq_in,
    output logic        busy
);

    localparam int unsigned NLINES = 8;
    localparam int unsigned SELW   = 3;
    localparam logic [15:0] PORT_STAT = PORT_CMD + 16'd1;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_INSERVICE = 1'b1
    } state_t;

    state_t              state_q;
    logic [NLINES-1:0]   irr_q;
    logic [NLINES-1:0]   irr_d;
    logic [NLINES-1:0]   imr_q;
    logic [7:0]          base_q;
    logic [SELW-1:0]     cur_q;
    logic                irq_q;
    logic [7:0]          irq_in_q;
    logic [7:0]          port_i_q;
    logic [7:0]          port_i_d;

    logic [NLINES-1:0]   pend;
    logic [NLINES-1:0]   sel_mask;
    logic [SELW-1:0]     sel;
    logic                dispatch;
    logic                cmd_wr;
    logic                eoi;
    logic                base_wr;
    logic                mask_wr;

    // Dispatch decision, priority select, port decode and next IRR / read data.
    always_comb begin
        pend     = irr_q & ~imr_q;
        dispatch = (state_q == ST_IDLE) && (pend != '0);

        // Scan from the top so the lowest set index wins.
        sel = '0;
        for (int i = NLINES - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel = SELW'(i);
            end
        end
        sel_mask = NLINES'(1) << sel;

        cmd_wr  = port_w && (port_a == PORT_CMD);
        eoi     = cmd_wr && (port_o[7:5] == 3'b001) && (state_q == ST_INSERVICE);
        base_wr = cmd_wr && (port_o[7:5] == 3'b000);
        mask_wr = port_w && (port_a == PORT_MASK);

        // Clear the dispatched line first so a coincident strobe re-latches it.
        irr_d = (irr_q & ~(dispatch ? sel_mask : '0)) | req;

        // Reads see registered (pre-write) state.
        port_i_d = port_i_q;
        if (port_r) begin
            if (port_a == PORT_CMD) begin
                port_i_d = irr_q;
            end else if (port_a == PORT_MASK) begin
                port_i_d = imr_q;
            end else if (port_a == PORT_STAT) begin
                port_i_d = {(state_q == ST_INSERVICE), 4'b0000, cur_q};
            end
        end
    end

    // State machine and all registered state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            irr_q    <= '0;
            imr_q    <= '0;
            base_q   <= BASE_RST;
            cur_q    <= '0;
            irq_q    <= 1'b0;
            irq_in_q <= BASE_RST;
            port_i_q <= '0;
        end else begin
            irr_q    <= irr_d;
            port_i_q <= port_i_d;
            if (mask_wr) begin
                imr_q <= port_o;
            end
            if (base_wr) begin
                base_q <= {port_o[4:0], 3'b000};
            end
            case (state_q)
                ST_IDLE: begin
                    if (dispatch) begin
                        state_q  <= ST_INSERVICE;
                        cur_q    <= sel;
                        irq_in_q <= base_q + 8'(sel);
                        irq_q    <= ~irq_q;
                    end
                end
                ST_INSERVICE: begin
                    if (eoi) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign port_i = port_i_q;
    assign irq    = irq_q;
    assign irq_in = irq_in_q;
    assign busy   = (state_q == ST_INSERVICE);

endmodule

// File: tb/tb_pic_ctrl.sv
// Directed bench for pic_ctrl: expected vectors are queued as stimulus is
// driven and matched against each observed irq toggle.
module tb_pic_ctrl;

    localparam logic [15:0] A_CMD  = 16'h0020;
    localparam logic [15:0] A_STAT = 16'h0021;
    localparam logic [15:0] A_MASK = 16'h00A0;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  req     = '0;
    logic [15:0] port_a  = '0;
    logic        port_w  = 1'b0;
    logic        port_r  = 1'b0;
    logic [7:0]  port_o  = '0;
    logic [7:0]  port_i;
    logic        irq;
    logic [7:0]  irq_in;
    logic        busy;

    always #5 clock = ~clock;

    pic_ctrl dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .port_a  (port_a),
        .port_w  (port_w),
        .port_r  (port_r),
        .port_o  (port_o),
        .port_i  (port_i),
        .irq     (irq),
        .irq_in  (irq_in),
        .busy    (busy)
    );

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  vec;
    } ev_t;

    ev_t         got_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] cyc_cnt     = '0;
    logic        rst_at_edge = 1'b1;
    logic        irq_last    = 1'b0;
    int          checks      = 0;
    int          failures    = 0;

    // Edge counter and record of whether the last edge was a reset edge.
    always @(posedge clock) begin
        cyc_cnt     <= cyc_cnt + 32'd1;
        rst_at_edge <= !reset_n;
    end

    // Every irq toggle outside reset is one interrupt event.
    always @(negedge clock) begin
        if (irq !== irq_last && !rst_at_edge) begin
            got_q.push_back({cyc_cnt, irq_in});
        end
        irq_last <= irq;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_req(input logic [7:0] v);
        req = v;
        cyc(1);
        req = '0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        port_a = a;
        port_o = d;
        port_w = 1'b1;
        cyc(1);
        port_w = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [7:0] d);
        port_a = a;
        port_r = 1'b1;
        cyc(1);
        port_r = 1'b0;
        d = port_i;
    endtask

    // Pop the next observed toggle and match it against the next expected vector.
    task automatic wait_irq(input string tag, input logic [31:0] exp_cyc, input bit check_cyc);
        int         n;
        ev_t        ev;
        logic [7:0] e;
        n = 0;
        while (got_q.size() == 0 && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++;
        assert (got_q.size() != 0) else begin
            failures++;
            $error("FAIL %s timeout observed=none expected=toggle", tag);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        if (got_q.size() != 0) begin
            ev = got_q.pop_front();
            chk({tag, " vec"}, 32'(ev.vec), 32'(e));
            if (check_cyc) begin
                chk({tag, " lat"}, ev.cyc, exp_cyc);
            end
        end
    endtask

    task automatic expect_none(input string tag, input int n);
        cyc(n);
        chk(tag, 32'(got_q.size()), 32'd0);
        got_q.delete();
    endtask

    initial begin
        logic [7:0]  d;
        logic [31:0] s;

        // Reset state
        reset_n = 1'b0;
        cyc(3);
        chk("rst port_i", 32'(port_i), 32'h00);
        chk("rst irq", 32'(irq), 32'h0);
        chk("rst irq_in", 32'(irq_in), 32'h08);
        chk("rst busy", 32'(busy), 32'h0);
        reset_n = 1'b1;
        cyc(1);
        rd(A_CMD, d);  chk("rst irr", 32'(d), 32'h00);
        rd(A_MASK, d); chk("rst imr", 32'(d), 32'h00);

        // Single timer request: toggle two cycles after the strobe
        exp_q.push_back(8'h08);
        s = cyc_cnt;
        pulse_req(8'h01);
        wait_irq("t1", s + 32'd2, 1'b1);
        chk("t1 irq level", 32'(irq), 32'h1);
        chk("t1 busy", 32'(busy), 32'h1);
        rd(A_STAT, d);   chk("t1 status", 32'(d), 32'h80);
        rd(16'h0030, d); chk("t1 unmapped read holds", 32'(d), 32'h80);
        wr(A_CMD, 8'h20);
        chk("t1 eoi clears busy", 32'(busy), 32'h0);

        // EOI while idle, unmapped writes, read-during-write
        wr(A_CMD, 8'h20);
        chk("idle eoi busy", 32'(busy), 32'h0);
        expect_none("idle eoi no toggle", 3);
        wr(16'h00A1, 8'hFF);
        wr(A_STAT, 8'h1F);
        rd(A_MASK, d); chk("unmapped write ignored", 32'(d), 32'h00);
        port_a = A_MASK; port_o = 8'h55; port_w = 1'b1; port_r = 1'b1;
        cyc(1);
        port_w = 1'b0; port_r = 1'b0;
        chk("rw returns pre-write", 32'(port_i), 32'h00);
        rd(A_MASK, d); chk("rw write landed", 32'(d), 32'h55);
        wr(A_MASK, 8'h00);

        // Two lines at once: priority, EOI hand-off, no third toggle
        exp_q.push_back(8'h09);
        s = cyc_cnt;
        pulse_req(8'h06);
        wait_irq("t2 first", s + 32'd2, 1'b1);
        expect_none("t2 held while busy", 4);
        rd(A_CMD, d); chk("t2 irr pending", 32'(d), 32'h04);
        exp_q.push_back(8'h0A);
        s = cyc_cnt;
        wr(A_CMD, 8'h20);
        wait_irq("t2 after eoi", s + 32'd2, 1'b1);
        expect_none("t2 no third toggle", 6);
        chk("t2 busy", 32'(busy), 32'h1);
        wr(A_CMD, 8'h20);

        // Masked line stays latched, dispatches once unmasked
        wr(A_MASK, 8'h04);
        pulse_req(8'h04);
        expect_none("t3 masked", 4);
        rd(A_CMD, d); chk("t3 irr latched", 32'(d), 32'h04);
        exp_q.push_back(8'h0A);
        s = cyc_cnt;
        wr(A_MASK, 8'h00);
        wait_irq("t3 unmask", s + 32'd2, 1'b1);
        wr(A_CMD, 8'h20);

        // Vector base write
        wr(A_CMD, 8'h10);
        exp_q.push_back(8'h87);
        s = cyc_cnt;
        pulse_req(8'h80);
        wait_irq("t4 base", s + 32'd2, 1'b1);
        wr(A_CMD, 8'h20);

        // Request coinciding with its own dispatch is retained
        exp_q.push_back(8'h81);
        s = cyc_cnt;
        req = 8'h02;
        cyc(2);
        req = '0;
        wait_irq("t5 first", s + 32'd2, 1'b1);
        rd(A_CMD, d); chk("t5 irr retained", 32'(d), 32'h02);
        exp_q.push_back(8'h81);
        s = cyc_cnt;
        wr(A_CMD, 8'h20);
        wait_irq("t5 second", s + 32'd2, 1'b1);
        wr(A_CMD, 8'h20);
        expect_none("t5 no more", 4);
        rd(A_CMD, d); chk("t5 irr empty", 32'(d), 32'h00);

        // Reset mid-service with pending requests
        exp_q.push_back(8'h80);
        s = cyc_cnt;
        pulse_req(8'h01);
        wait_irq("t6 setup", s + 32'd2, 1'b1);
        pulse_req(8'h05);
        rd(A_CMD, d); chk("t6 irr before rst", 32'(d), 32'h05);
        chk("t6 busy before rst", 32'(busy), 32'h1);
        reset_n = 1'b0;
        req = 8'h02;
        cyc(1);
        reset_n = 1'b1;
        req = '0;
        chk("t6 irq after rst", 32'(irq), 32'h0);
        chk("t6 busy after rst", 32'(busy), 32'h0);
        chk("t6 irq_in after rst", 32'(irq_in), 32'h08);
        rd(A_CMD, d); chk("t6 irr after rst", 32'(d), 32'h00);
        expect_none("t6 no dispatch", 5);
        exp_q.push_back(8'h08);
        s = cyc_cnt;
        pulse_req(8'h01);
        wait_irq("t6 new req", s + 32'd2, 1'b1);
        chk("scoreboard drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
